// File: rtl/aes128_pkg.sv
// AES-128 shared definitions: round/key-word counts, key-FSM state type,
// Rcon, forward/inverse S-box, GF(2^8) helpers (poly 0x11B) and
// byte/word accessors for 128-bit states in FIPS byte order
// (byte 0 = bits 127:120, word 0 = bits 127:96).
package aes128_pkg;

  localparam int unsigned NR = 10;
  localparam int unsigned NK = 4;

  typedef enum logic {
    KS_IDLE,
    KS_EXPAND
  } ks_state_e;

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254; maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] res;
    logic [7:0] base;
    res  = 8'h01;
    base = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (i != 0) res = gf_mul(res, base);
      base = gf_mul(base, base);
    end
    return res;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int unsigned n);
    logic [15:0] d;
    d = {x, x} << n;
    return d[15:8];
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] x;
    x = gf_inv(a);
    return x ^ rotl8(x, 1) ^ rotl8(x, 2) ^ rotl8(x, 3) ^ rotl8(x, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    return gf_inv(rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05);
  endfunction

  function automatic logic [7:0] get_byte(input logic [127:0] s, input int unsigned i);
    return s[127 - 8*i -: 8];
  endfunction

  function automatic logic [31:0] get_word(input logic [127:0] s, input int unsigned w);
    return s[127 - 32*w -: 32];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // One step of the key expansion: the full next round key from the previous one.
  function automatic logic [127:0] key_expand(input logic [127:0] prev, input logic [7:0] rc);
    logic [31:0]  w;
    logic [127:0] nxt;
    w   = get_word(prev, NK - 1);
    w   = sub_word({w[23:0], w[31:24]}) ^ {rc, 24'h000000};
    nxt = '0;
    for (int unsigned i = 0; i < NK; i++) begin
      w = w ^ get_word(prev, i);
      nxt[127 - 32*i -: 32] = w;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/aes128_inv_round.sv
// One combinational AES-128 inverse round:
// InvShiftRows -> InvSubBytes -> AddRoundKey -> InvMixColumns (skipped when i_is_last).
//   i_state      : round input state
//   i_round_key  : round key to add
//   i_is_last    : 1 = final round, no InvMixColumns
//   o_state      : round output state
module aes128_inv_round
  import aes128_pkg::*;
(
  input  logic [127:0] i_state,
  input  logic [127:0] i_round_key,
  input  logic         i_is_last,
  output logic [127:0] o_state
);

  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
            gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
            gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
            gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
  endfunction

  logic [127:0] shifted;
  logic [127:0] added;
  logic [127:0] mixed;

  always_comb begin
    shifted = '0;
    added   = '0;
    mixed   = '0;
    // Byte (r, c) sits at index r + 4c; row r rotates right by r columns.
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned r = 0; r < 4; r++) begin
        shifted[127 - 8*(r + 4*c) -: 8] = get_byte(i_state, r + 4*((c + 4 - r) % 4));
      end
    end
    for (int unsigned i = 0; i < 16; i++) begin
      added[127 - 8*i -: 8] = inv_sbox(get_byte(shifted, i)) ^ get_byte(i_round_key, i);
    end
    for (int unsigned c = 0; c < 4; c++) begin
      mixed[127 - 32*c -: 32] = inv_mix_col(get_word(added, c));
    end
    o_state = i_is_last ? added : mixed;
  end

endmodule

// File: rtl/aes128_dec.sv
// Pipelined AES-128 inverse cipher with an iterative key schedule.
//   i_clk, i_rst_n        : clock, async active-low reset
//   i_key                 : cipher key, sampled with i_start_key_schedule
//   i_start_key_schedule  : pulse to (re)start key expansion; flushes the pipeline
//   o_done_key_schedule   : one-cycle pulse once all 11 round keys are stored
//   i_data, i_start       : ciphertext block and its valid (accepted once keys are ready)
//   o_data, o_done        : plaintext block and its valid, 11 cycles after acceptance
module aes128_dec
  import aes128_pkg::*;
(
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [127:0] i_key,
  input  logic         i_start_key_schedule,
  output logic         o_done_key_schedule,
  input  logic [127:0] i_data,
  input  logic         i_start,
  output logic [127:0] o_data,
  output logic         o_done
);

  ks_state_e    ks_state_q, ks_state_d;
  logic [3:0]   ks_cnt_q, ks_cnt_d;
  logic         keys_valid_q, keys_valid_d;
  logic         done_ks_q, done_ks_d;
  logic [127:0] rk_q [0:NR];
  logic [127:0] rk_d [0:NR];

  logic [127:0] st_q [0:NR];
  logic [127:0] st_d [0:NR];
  logic [NR:0]  vld_q, vld_d;
  logic [127:0] o_data_q, o_data_d;
  logic         o_done_q, o_done_d;

  logic [127:0] round_out [1:NR];
  logic [127:0] prev_key;
  logic         flush;
  logic         accept;

  for (genvar k = 1; k <= NR; k++) begin : g_round
    aes128_inv_round u_round (
      .i_state     (st_q[k-1]),
      .i_round_key (rk_q[NR-k]),
      .i_is_last   (k == NR),
      .o_state     (round_out[k])
    );
  end

  // Key schedule FSM.
  always_comb begin
    ks_state_d   = ks_state_q;
    ks_cnt_d     = ks_cnt_q;
    keys_valid_d = keys_valid_q;
    done_ks_d    = 1'b0;
    flush        = 1'b0;
    prev_key     = '0;
    for (int unsigned r = 0; r <= NR; r++) rk_d[r] = rk_q[r];
    for (int unsigned r = 0; r < NR; r++) begin
      if (4'(r + 1) == ks_cnt_q) prev_key = rk_q[r];
    end

    if (i_start_key_schedule) begin
      ks_state_d   = KS_EXPAND;
      rk_d[0]      = i_key;
      ks_cnt_d     = 4'd1;
      keys_valid_d = 1'b0;
      flush        = 1'b1;
    end else if (ks_state_q == KS_EXPAND) begin
      for (int unsigned r = 1; r <= NR; r++) begin
        if (4'(r) == ks_cnt_q) rk_d[r] = key_expand(prev_key, rcon(ks_cnt_q));
      end
      ks_cnt_d = ks_cnt_q + 4'd1;
      if (ks_cnt_q == 4'(NR)) begin
        ks_state_d   = KS_IDLE;
        keys_valid_d = 1'b1;
        done_ks_d    = 1'b1;
      end
    end
  end

  // Data pipeline; a key restart in the same cycle wins over a new block.
  always_comb begin
    accept  = i_start && keys_valid_q && (ks_state_q == KS_IDLE) && !i_start_key_schedule;
    st_d[0] = i_data ^ rk_q[NR];
    for (int unsigned k = 1; k <= NR; k++) st_d[k] = round_out[k];
    vld_d    = {vld_q[NR-1:0], accept};
    o_done_d = vld_q[NR] && !flush;
    o_data_d = o_done_d ? st_q[NR] : o_data_q;
    if (flush) vld_d = '0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ks_state_q   <= KS_IDLE;
      ks_cnt_q     <= '0;
      keys_valid_q <= 1'b0;
      done_ks_q    <= 1'b0;
      vld_q        <= '0;
      o_data_q     <= '0;
      o_done_q     <= 1'b0;
    end else begin
      ks_state_q   <= ks_state_d;
      ks_cnt_q     <= ks_cnt_d;
      keys_valid_q <= keys_valid_d;
      done_ks_q    <= done_ks_d;
      vld_q        <= vld_d;
      o_data_q     <= o_data_d;
      o_done_q     <= o_done_d;
    end
  end

  // Round keys and stage data are qualified by keys_valid / valid bits.
  always_ff @(posedge i_clk) begin
    for (int unsigned r = 0; r <= NR; r++) begin
      rk_q[r] <= rk_d[r];
      st_q[r] <= st_d[r];
    end
  end

  assign o_done_key_schedule = done_ks_q;
  assign o_data              = o_data_q;
  assign o_done              = o_done_q;

endmodule

// File: tb/tb_aes128_dec.sv
// Scoreboard bench for aes128_dec: the driver pushes expected plaintexts with
// their due cycle, a negedge monitor pops and compares on every o_done.
module tb_aes128_dec;

  logic         clk;
  logic         rst_n;
  logic [127:0] key;
  logic         start_ks;
  logic         done_ks;
  logic [127:0] din;
  logic         start;
  logic [127:0] dout;
  logic         done;

  aes128_dec u_dut (
    .i_clk                (clk),
    .i_rst_n              (rst_n),
    .i_key                (key),
    .i_start_key_schedule (start_ks),
    .o_done_key_schedule  (done_ks),
    .i_data               (din),
    .i_start              (start),
    .o_data               (dout),
    .o_done               (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] data;
    int unsigned  due;
  } exp_t;

  exp_t        q[$];
  int unsigned cyc = 0;
  int unsigned n_done = 0;
  int          tests = 0;
  int          fails = 0;
  logic [7:0]  sbox_t [256];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model (forward cipher) ----------------
  function automatic logic [7:0] rl8(input logic [7:0] v, input int n);
    logic [7:0] r;
    r = v;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  function automatic logic [7:0] m2(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  task automatic build_sbox();
    logic [7:0] p, qq, x;
    p  = 8'h01;
    qq = 8'h01;
    do begin
      p  = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      qq = qq ^ {qq[6:0], 1'b0};
      qq = qq ^ {qq[5:0], 2'b00};
      qq = qq ^ {qq[3:0], 4'h0};
      if (qq[7]) qq = qq ^ 8'h09;
      x = qq ^ rl8(qq, 1) ^ rl8(qq, 2) ^ rl8(qq, 3) ^ rl8(qq, 4);
      sbox_t[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox_t[0] = 8'h63;
  endtask

  function automatic logic [127:0] ref_encrypt(input logic [127:0] k, input logic [127:0] pt);
    logic [7:0]   w [176];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   tw [4];
    logic [7:0]   rc, x, a0, a1, a2, a3;
    logic [127:0] out;
    for (int i = 0; i < 16; i++) w[i] = k[127 - 8*i -: 8];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      for (int j = 0; j < 4; j++) tw[j] = w[4*(i-1) + j];
      if (i % 4 == 0) begin
        x     = tw[0];
        tw[0] = sbox_t[tw[1]] ^ rc;
        tw[1] = sbox_t[tw[2]];
        tw[2] = sbox_t[tw[3]];
        tw[3] = sbox_t[x];
        rc    = m2(rc);
      end
      for (int j = 0; j < 4; j++) w[4*i + j] = w[4*(i-4) + j] ^ tw[j];
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127 - 8*i -: 8] ^ w[i];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int i = 0; i < 16; i++) s[i] = sbox_t[s[i]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) t[r + 4*c] = s[r + 4*((c + r) % 4)];
      if (rnd < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
          s[4*c]   = m2(a0) ^ m2(a1) ^ a1 ^ a2 ^ a3;
          s[4*c+1] = a0 ^ m2(a1) ^ m2(a2) ^ a2 ^ a3;
          s[4*c+2] = a0 ^ a1 ^ m2(a2) ^ m2(a3) ^ a3;
          s[4*c+3] = m2(a0) ^ a0 ^ a1 ^ a2 ^ m2(a3);
        end
      end else begin
        s = t;
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[16*rnd + i];
    end
    out = '0;
    for (int i = 0; i < 16; i++) out[127 - 8*i -: 8] = s[i];
    return out;
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (done) begin
      n_done++;
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL spurious_done: got o_done=1 with data %h at cycle %0d, required no output", dout, cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("data", dout, e.data);
        check("latency", 128'(cyc), 128'(e.due));
      end
    end else if (q.size() != 0 && q[0].due <= cyc) begin
      exp_t e;
      e = q.pop_front();
      tests++;
      fails++;
      $display("FAIL missing_done: got o_done=0 at cycle %0d, required data %h", cyc, e.data);
    end
  end

  // ---------------- driver helpers ----------------
  task automatic send(input logic [127:0] d, input bit expect_out, input logic [127:0] exp);
    @(negedge clk);
    din   = d;
    start = 1'b1;
    if (expect_out) q.push_back('{exp, cyc + 12});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  task automatic drain();
    for (int n = 0; n < 40 && q.size() != 0; n++) @(negedge clk);
    check("drain_queue_empty", 128'(q.size()), 128'd0);
    q.delete();
  endtask

  task automatic do_key(input logic [127:0] k, input bit inject);
    int unsigned c0;
    bit          seen;
    @(negedge clk);
    key      = k;
    start_ks = 1'b1;
    start    = 1'b0;
    c0       = cyc;
    @(negedge clk);
    start_ks = 1'b0;
    key      = {$urandom, $urandom, $urandom, $urandom};
    seen     = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      if (done_ks) begin
        seen = 1'b1;
      end else begin
        start = inject;
        din   = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
      end
    end
    start = 1'b0;
    check("ks_done_seen", 128'(seen), 128'd1);
    check("ks_done_cycle", 128'(cyc), 128'(c0 + 11));
    @(negedge clk);
    check("ks_done_width", 128'(done_ks), 128'd0);
  endtask

  localparam logic [127:0] KEY_C1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_C1   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT_C1   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY_TM  = 128'h129cd242996d818ca55c2abbff0ddc61;

  logic [127:0] ct_tm [3];
  logic [127:0] pt_tm [3];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no end of test, required $finish before 1 ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned snap;
    logic [127:0] rk, pt;
    ct_tm[0] = 128'ha35b3cb11eb233638fd2aa248ffdd579;
    ct_tm[1] = 128'h0025d29b796c4a43cbf8fe2474f461c3;
    ct_tm[2] = 128'hb1d95531148a2c8a62b4773a07b638e9;
    pt_tm[0] = 128'h1a120000000000000000000000000000;
    pt_tm[1] = 128'h00112233445566778899aabbccddeeff;
    pt_tm[2] = 128'h00112233445566778899aabbccddeefe;
    build_sbox();

    rst_n    = 1'b1;
    key      = '0;
    start_ks = 1'b0;
    din      = '0;
    start    = 1'b0;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_o_data", dout, 128'd0);
    check("reset_o_done", 128'(done), 128'd0);
    check("reset_o_done_ks", 128'(done_ks), 128'd0);
    rst_n = 1'b1;

    // Blocks without any key schedule are ignored.
    snap = n_done;
    send(CT_C1, 1'b0, '0);
    send(CT_C1, 1'b0, '0);
    idle(20);
    check("no_key_no_done", 128'(n_done), 128'(snap));

    // C.1 key, with i_start pulses issued during EXPAND.
    snap = n_done;
    do_key(KEY_C1, 1'b1);
    idle(15);
    check("expand_blocks_dropped", 128'(n_done), 128'(snap));
    send(CT_C1, 1'b1, PT_C1);
    idle(1);
    drain();

    // Team vectors, back to back.
    do_key(KEY_TM, 1'b0);
    for (int i = 0; i < 3; i++) send(ct_tm[i], 1'b1, pt_tm[i]);
    idle(1);
    drain();

    // Mid-stream rekey drops in-flight blocks.
    snap = n_done;
    for (int i = 0; i < 3; i++) send(ct_tm[i], 1'b0, '0);
    idle(3);
    do_key(KEY_C1, 1'b0);
    idle(15);
    check("rekey_blocks_dropped", 128'(n_done), 128'(snap));
    send(CT_C1, 1'b1, PT_C1);
    idle(1);
    drain();

    // Async reset between edges while blocks are in flight.
    for (int i = 0; i < 3; i++) send(ct_tm[i], 1'b0, '0);
    idle(3);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_o_done", 128'(done), 128'd0);
    check("async_rst_o_data", dout, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    snap = n_done;
    send(CT_C1, 1'b0, '0);
    send(CT_C1, 1'b0, '0);
    idle(20);
    check("post_reset_no_done", 128'(n_done), 128'(snap));

    // Round trip against the forward-cipher model.
    for (int t = 0; t < 100; t++) begin
      rk = {$urandom, $urandom, $urandom, $urandom};
      do_key(rk, 1'b0);
      for (int b = 0; b < 1 + int'($urandom_range(0, 2)); b++) begin
        pt = {$urandom, $urandom, $urandom, $urandom};
        send(ref_encrypt(rk, pt), 1'b1, pt);
        if ($urandom_range(0, 1) == 1) idle(1);
      end
      idle(1);
      drain();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/aes128_dec.md
Name: aes128_dec

Overview:
- Pipelined AES-128 inverse cipher (FIPS-197 InvCipher). It is the decrypt counterpart of the aes128 encrypt core, with the same start/done streaming interface.
- An internal iterative key schedule expands the cipher key once and stores all 11 round keys. After that, one ciphertext block per cycle enters a 10-round inverse pipeline.
- Used by the FrodoKEM datapath wherever AES-128 decryption is needed.

Parameters:
- Nr, 10, number of rounds; fixed for AES-128.
- Nk, 4, number of 32-bit key words; fixed for AES-128.

Ports:
- i_clk  in  1  clock; all state changes on rising edge.
- i_rst_n  in  1  asynchronous reset, active-low.
- i_key  in  128  cipher key; sampled in the cycle i_start_key_schedule=1.
- i_start_key_schedule  in  1  one-cycle pulse that starts key expansion.
- o_done_key_schedule  out  1  one-cycle pulse when all round keys are valid.
- i_data  in  128  ciphertext block, FIPS byte order (byte 0 = bits 127:120).
- i_start  in  1  i_data is valid this cycle; may be held high for back-to-back blocks.
- o_data  out  128  plaintext block.
- o_done  out  1  o_data is valid this cycle.

Behaviour:
- Reset (async, i_rst_n=0): o_data=0, o_done=0, o_done_key_schedule=0. All pipeline valid bits clear, keys_valid=0, key FSM in IDLE. Round-key registers need no reset.
- Key FSM states:
  - IDLE -> EXPAND on i_start_key_schedule=1. In that cycle: rk[0]=i_key, round counter=1, keys_valid=0, all pipeline valid bits cleared (in-flight blocks are dropped, no o_done for them).
  - EXPAND: one round key per cycle, rk[r] = f(rk[r-1], Rcon[r]), r=1..10.
  - EXPAND -> IDLE after rk[10] is written. In that same edge: keys_valid=1 and o_done_key_schedule=1 for exactly one cycle.
  - Latency: o_done_key_schedule is high 10 cycles after the edge that sampled the start pulse.
  - i_start_key_schedule during EXPAND restarts expansion with the new i_key.
- Data entry: i_start is accepted only when keys_valid=1 and the key FSM is IDLE. Otherwise it is ignored: nothing enters the pipeline and o_done never fires for it.
- Pipeline:
  - Stage 0 registers i_data ^ rk[10].
  - Stage k=1..9 registers AddRoundKey(InvMixColumns? no) — precisely: InvShiftRows, InvSubBytes, AddRoundKey rk[10-k], then InvMixColumns.
  - Stage 10 registers InvShiftRows, InvSubBytes, AddRoundKey rk[0]; no InvMixColumns.
  - A valid bit travels with each stage.
- Latency: o_done=1 exactly 11 cycles after the accepting edge, i.e. first result at edge N+11. Throughput is 1 block/cycle, and output order equals input order.
- o_data holds its last value when o_done=0; it is not cleared between results.
- Simultaneous i_start_key_schedule and i_start: the key restart wins, and the block is dropped.
- Reset mid-operation: key expansion and all in-flight blocks are abandoned; keys_valid=0 until a new expansion completes.
- GF(2^8) arithmetic uses reduction polynomial 0x11B. InvMixColumns coefficients are 0e,0b,0d,09.

Decomposition:
- Package aes128_pkg:
  - Nr, Nk constants.
  - Rcon table (01..36).
  - Forward S-box function, used by the key schedule.
  - Inverse S-box function.
  - xtime and gf_mul helpers.
  - Byte/word index helpers.
- Sub-module aes128_inv_round:
  - Ports: state in, round key in, is_last in, state out.
  - Purely combinational round: InvShiftRows, InvSubBytes, AddRoundKey, then InvMixColumns unless is_last.
  - Instantiated 10 times by a generate loop; aes128_dec owns all registers.

Test Plan:
- FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, expand, then i_data=69c4e0d86a7b0430d8cdb78070b4c55a -> o_data=00112233445566778899aabbccddeeff at exactly +11 cycles.
- Team vectors, 3 back-to-back blocks under key 129cd242996d818ca55c2abbff0ddc61:
  - a35b3cb11eb233638fd2aa248ffdd579 -> 1a120000000000000000000000000000
  - 0025d29b796c4a43cbf8fe2474f461c3 -> 00112233445566778899aabbccddeeff
  - b1d95531148a2c8a62b4773a07b638e9 -> 00112233445566778899aabbccddeefe
  - Required: results on three consecutive cycles, with o_done high for those 3 cycles only.
- Key schedule timing: pulse start -> o_done_key_schedule high for exactly 1 cycle, 10 cycles later. i_start pulses issued during EXPAND produce no o_done.
- Mid-stream rekey: feed 3 blocks, pulse i_start_key_schedule 4 cycles later with key 000102..0f -> the 3 blocks never emit o_done. A C.1 block entered after the new done pulse decrypts correctly.
- Async reset: assert i_rst_n=0 mid-pipeline, between clock edges -> o_done=0 and o_data=0 immediately. After release, i_start with no key expansion produces no o_done within 20 cycles.
- Round trip: 100 random keys and blocks encrypted by aes128, with the result fed into aes128_dec -> output equals the original plaintext every time.
